// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing the single RAM/IO port between fetch, load buffer and store commit.
// Multi-byte accesses are issued little-endian, one byte per cycle; loads are extended per func3.
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int IO_SEL_HI = 17,
  parameter int IO_SEL_LO = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear_flag_in,
  input  logic              io_buffer_full,

  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,

  input  logic              lb_req_in,
  input  logic [ADDR_W-1:0] lb_addr_in,
  input  logic [2:0]        lb_func3_in,
  output logic              lb_done_out,
  output logic [31:0]       lb_data_out,

  input  logic              st_req_in,
  input  logic [ADDR_W-1:0] st_addr_in,
  input  logic [2:0]        st_func3_in,
  input  logic [31:0]       st_data_in,
  output logic              st_done_out,

  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LB, OWN_ST} owner_t;

  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  owner_t            owner_q;
  logic [2:0]        cnt_q;
  logic [2:0]        nbytes_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              wr_q;
  logic [31:0]       st_data_q;
  logic [31:0]       rbuf_q;
  logic              if_done_q;
  logic              lb_done_q;
  logic              st_done_q;
  logic [31:0]       if_data_q;
  logic [31:0]       lb_data_q;

  logic [ADDR_W-1:0] mem_a_d;
  logic              io_stall;
  logic [31:0]       rd_word;
  logic [31:0]       ext_word;

  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign mem_a_d  = mem_a_q + A_ONE;
  assign io_stall = (&mem_a_q[IO_SEL_HI:IO_SEL_LO]) && io_buffer_full;

  // The write strobe is qualified combinationally so a pause or a full IO buffer
  // suppresses the byte in the very cycle it occurs.
  assign mem_wr      = wr_q && rdy && !io_stall;
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign if_done_out = if_done_q;
  assign lb_done_out = lb_done_q;
  assign st_done_out = st_done_q;
  assign if_data_out = if_data_q;
  assign lb_data_out = lb_data_q;

  // Byte arriving now belongs to the address issued last cycle, i.e. index cnt_q-1.
  always_comb begin
    rd_word = rbuf_q;
    case (cnt_q)
      3'd1:    rd_word[7:0]   = mem_din;
      3'd2:    rd_word[15:8]  = mem_din;
      3'd3:    rd_word[23:16] = mem_din;
      3'd4:    rd_word[31:24] = mem_din;
      default: ;
    endcase
  end

  always_comb begin
    case (func3_q)
      3'd0:    ext_word = {{24{rd_word[7]}}, rd_word[7:0]};
      3'd1:    ext_word = {{16{rd_word[15]}}, rd_word[15:0]};
      3'd4:    ext_word = {24'h000000, rd_word[7:0]};
      3'd5:    ext_word = {16'h0000, rd_word[15:0]};
      default: ext_word = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      func3_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      wr_q       <= 1'b0;
      st_data_q  <= '0;
      rbuf_q     <= '0;
      if_done_q  <= 1'b0;
      lb_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      if_data_q  <= '0;
      lb_data_q  <= '0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      lb_done_q <= 1'b0;
      st_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q  <= '0;
          rbuf_q <= '0;
          if (st_req_in) begin
            state_q    <= S_WRITE;
            owner_q    <= OWN_ST;
            mem_a_q    <= st_addr_in;
            nbytes_q   <= byte_count(st_func3_in);
            mem_dout_q <= st_data_in[7:0];
            st_data_q  <= st_data_in >> 8;
            wr_q       <= 1'b1;
          end else if (lb_req_in && !clear_flag_in) begin
            state_q  <= S_READ;
            owner_q  <= OWN_LB;
            mem_a_q  <= lb_addr_in;
            nbytes_q <= byte_count(lb_func3_in);
            func3_q  <= lb_func3_in;
          end else if (if_req_in && !clear_flag_in) begin
            state_q  <= S_READ;
            owner_q  <= OWN_IF;
            mem_a_q  <= if_addr_in;
            nbytes_q <= 3'd4;
            func3_q  <= 3'd2;
          end
        end

        S_READ: begin
          if (clear_flag_in) begin
            state_q <= S_IDLE;
          end else begin
            if (cnt_q != 3'd0) rbuf_q <= rd_word;
            if (cnt_q == nbytes_q) begin
              state_q <= S_DONE;
              if (owner_q == OWN_IF) begin
                if_done_q <= 1'b1;
                if_data_q <= rd_word;
              end else begin
                lb_done_q <= 1'b1;
                lb_data_q <= ext_word;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
              if ((cnt_q + 3'd1) < nbytes_q) mem_a_q <= mem_a_d;
            end
          end
        end

        S_WRITE: begin
          if (!io_stall) begin
            if (cnt_q == nbytes_q - 3'd1) begin
              state_q   <= S_DONE;
              wr_q      <= 1'b0;
              st_done_q <= 1'b1;
            end else begin
              cnt_q      <= cnt_q + 3'd1;
              mem_a_q    <= mem_a_d;
              mem_dout_q <= st_data_q[7:0];
              st_data_q  <= st_data_q >> 8;
            end
          end
        end

        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single loads plus hand-written sequences
// for priority, IO stall, flush and pause behaviour.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, clear_flag_in, io_buffer_full;
  logic        if_req_in, lb_req_in, st_req_in;
  logic [31:0] if_addr_in, lb_addr_in, st_addr_in, st_data_in;
  logic [2:0]  lb_func3_in, st_func3_in;
  logic        if_done_out, lb_done_out, st_done_out;
  logic [31:0] if_data_out, lb_data_out;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_flag_in(clear_flag_in),
    .io_buffer_full(io_buffer_full),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_done_out(if_done_out), .if_data_out(if_data_out),
    .lb_req_in(lb_req_in), .lb_addr_in(lb_addr_in), .lb_func3_in(lb_func3_in),
    .lb_done_out(lb_done_out), .lb_data_out(lb_data_out),
    .st_req_in(st_req_in), .st_addr_in(st_addr_in), .st_func3_in(st_func3_in),
    .st_data_in(st_data_in), .st_done_out(st_done_out),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency; it shares the rdy pause with the arbiter.
  logic [7:0] pre  [logic [31:0]];
  logic [7:0] wram [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (wram.exists(a)) return wram[a];
    if (pre.exists(a))  return pre[a];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram_rd(mem_a);
      if (mem_wr) wram[mem_a] = mem_dout;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w, input int nb);
    for (int i = 0; i < nb; i++) pre[a + 32'(i)] = w[8*i +: 8];
  endtask

  // Called in an IDLE cycle at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_load(input logic is_if, input logic [31:0] addr, input logic [2:0] f3,
                          output logic [31:0] data, output int done_c,
                          output int wr_seen, output logic pulse_after);
    done_c  = -1;
    wr_seen = 0;
    data    = 'x;
    if (is_if) begin
      if_req_in  = 1'b1;
      if_addr_in = addr;
    end else begin
      lb_req_in   = 1'b1;
      lb_addr_in  = addr;
      lb_func3_in = f3;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_wr) wr_seen++;
      if (is_if ? if_done_out : lb_done_out) begin
        done_c = k;
        data   = is_if ? if_data_out : lb_data_out;
        break;
      end
    end
    if_req_in = 1'b0;
    lb_req_in = 1'b0;
    @(negedge clk);
    pulse_after = is_if ? if_done_out : lb_done_out;
  endtask

  typedef struct {
    logic        is_if;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] bytes;
    int          nb;
    logic [31:0] exp;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int          dc, ws;
    logic        pa;
    int          st_c, lb_c, if_c;
    logic        seen;
    logic [31:0] w;

    vecs[0] = '{1'b0, 32'h0000_0100, 3'd2, 32'h4433_2211, 4, 32'h4433_2211, 6};
    vecs[1] = '{1'b0, 32'h0000_0200, 3'd0, 32'h0000_0080, 1, 32'hFFFF_FF80, 3};
    vecs[2] = '{1'b0, 32'h0000_0200, 3'd4, 32'h0000_0080, 1, 32'h0000_0080, 3};
    vecs[3] = '{1'b0, 32'h0000_0210, 3'd1, 32'h0000_9234, 2, 32'hFFFF_9234, 4};
    vecs[4] = '{1'b0, 32'h0000_0210, 3'd5, 32'h0000_9234, 2, 32'h0000_9234, 4};
    vecs[5] = '{1'b0, 32'h0000_0220, 3'd1, 32'h0000_1234, 2, 32'h0000_1234, 4};
    vecs[6] = '{1'b1, 32'h0000_0400, 3'd2, 32'hEFBE_ADDE, 4, 32'hEFBE_ADDE, 6};
    vecs[7] = '{1'b0, 32'hFFFF_FFFE, 3'd2, 32'hD4C3_B2A1, 4, 32'hD4C3_B2A1, 6};
    vecs[8] = '{1'b0, 32'h0000_0230, 3'd0, 32'h0000_007F, 1, 32'h0000_007F, 3};

    rst = 1'b1; rdy = 1'b1; clear_flag_in = 1'b0; io_buffer_full = 1'b0;
    if_req_in = 1'b0; lb_req_in = 1'b0; st_req_in = 1'b0;
    if_addr_in = '0; lb_addr_in = '0; st_addr_in = '0; st_data_in = '0;
    lb_func3_in = '0; st_func3_in = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset mem_wr", mem_wr, 0);
    chk("reset mem_a", mem_a, 0);
    chk("reset mem_dout", mem_dout, 0);
    chk("reset dones", {if_done_out, lb_done_out, st_done_out}, 0);
    chk("reset if_data", if_data_out, 0);
    chk("reset lb_data", lb_data_out, 0);

    for (int i = 0; i < 9; i++) begin
      preload(vecs[i].addr, vecs[i].bytes, vecs[i].nb);
      run_load(vecs[i].is_if, vecs[i].addr, vecs[i].f3, d, dc, ws, pa);
      chk($sformatf("vec%0d data", i), d, vecs[i].exp);
      chk($sformatf("vec%0d done cycle", i), dc, vecs[i].exp_cyc);
      chk($sformatf("vec%0d single pulse", i), pa, 0);
      chk($sformatf("vec%0d no write", i), ws, 0);
    end

    // Priority: ST, then LB, then IF, one IDLE cycle between each.
    st_c = -1; lb_c = -1; if_c = -1;
    st_req_in = 1'b1; st_addr_in = 32'h500; st_func3_in = 3'd0; st_data_in = 32'h0000_005A;
    lb_req_in = 1'b1; lb_addr_in = 32'h200; lb_func3_in = 3'd0;
    if_req_in = 1'b1; if_addr_in = 32'h100;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (st_done_out) begin st_c = k; st_req_in = 1'b0; end
      if (lb_done_out) begin lb_c = k; lb_req_in = 1'b0; end
      if (if_done_out) begin if_c = k; if_req_in = 1'b0; break; end
    end
    st_req_in = 1'b0; lb_req_in = 1'b0; if_req_in = 1'b0;
    chk("prio st done cycle", st_c, 2);
    chk("prio lb done cycle", lb_c, 6);
    chk("prio if done cycle", if_c, 13);
    chk("prio lb data", lb_data_out, 32'hFFFF_FF80);
    chk("prio if data", if_data_out, 32'h4433_2211);
    chk("prio store byte", ram_rd(32'h500), 8'h5A);
    @(negedge clk);
    chk("prio if pulse ends", if_done_out, 0);

    // SH to IO space with the IO buffer full for three cycles.
    st_req_in = 1'b1; st_addr_in = 32'h0003_0000; st_func3_in = 3'd1;
    st_data_in = 32'h1234_BEEF; io_buffer_full = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("io stall c%0d mem_wr", k), mem_wr, 0);
    end
    @(posedge clk); #1 io_buffer_full = 1'b0;
    @(negedge clk);
    chk("io byte0 wr/addr/data", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0003_0000, 8'hEF});
    @(negedge clk);
    chk("io byte1 wr/addr/data", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0003_0001, 8'hBE});
    @(negedge clk);
    chk("io st_done", st_done_out, 1);
    chk("io done no write", mem_wr, 0);
    st_req_in = 1'b0;
    @(negedge clk);
    chk("io st_done single", st_done_out, 0);
    chk("io stored bytes", {ram_rd(32'h0003_0001), ram_rd(32'h0003_0000)}, 16'hBEEF);

    // Flush during a fetch; the pending store is served next.
    seen = 1'b0;
    if_req_in = 1'b1; if_addr_in = 32'h400;
    @(negedge clk);
    chk("flush c1 mem_a", mem_a, 32'h400);
    st_req_in = 1'b1; st_addr_in = 32'h600; st_func3_in = 3'd0; st_data_in = 32'h0000_0077;
    @(negedge clk);
    chk("flush c2 mem_a", mem_a, 32'h401);
    @(posedge clk); #1 clear_flag_in = 1'b1; if_req_in = 1'b0;
    @(negedge clk);
    if (if_done_out) seen = 1'b1;
    chk("flush c3 mem_a", mem_a, 32'h402);
    @(posedge clk); #1 clear_flag_in = 1'b0;
    @(negedge clk);
    if (if_done_out) seen = 1'b1;
    chk("flush idle no write", mem_wr, 0);
    @(negedge clk);
    if (if_done_out) seen = 1'b1;
    chk("flush st wr/addr/data", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h600, 8'h77});
    @(negedge clk);
    if (if_done_out) seen = 1'b1;
    chk("flush st_done", st_done_out, 1);
    st_req_in = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (if_done_out) seen = 1'b1;
    end
    chk("flush no if_done", seen, 0);
    chk("flush if_data held", if_data_out, 32'h4433_2211);

    // Two-cycle pause in the middle of a LW.
    dc = -1;
    lb_req_in = 1'b1; lb_addr_in = 32'h100; lb_func3_in = 3'd2;
    @(negedge clk);
    @(negedge clk);
    chk("pause c2 mem_a", mem_a, 32'h101);
    @(posedge clk); #1 rdy = 1'b0;
    @(negedge clk);
    chk("pause c3 mem_a/wr", {mem_a, mem_wr}, {32'h102, 1'b0});
    @(negedge clk);
    chk("pause c4 mem_a/wr", {mem_a, mem_wr}, {32'h102, 1'b0});
    @(posedge clk); #1 rdy = 1'b1;
    for (int k = 5; k <= 20; k++) begin
      @(negedge clk);
      if (lb_done_out) begin dc = k; break; end
    end
    lb_req_in = 1'b0;
    chk("pause done cycle", dc, 8);
    chk("pause data", lb_data_out, 32'h4433_2211);
    @(negedge clk);

    // Pause during a store byte suppresses the strobe.
    st_req_in = 1'b1; st_addr_in = 32'h700; st_func3_in = 3'd0; st_data_in = 32'h0000_003C;
    @(posedge clk); #1 rdy = 1'b0;
    @(negedge clk);
    chk("pause store no write", mem_wr, 0);
    @(posedge clk); #1 rdy = 1'b1;
    @(negedge clk);
    chk("pause store wr/addr/data", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h700, 8'h3C});
    @(negedge clk);
    chk("pause store done", st_done_out, 1);
    st_req_in = 1'b0;
    @(negedge clk);

    // SW outside IO space is not stalled by a full IO buffer; read it back.
    w = 32'hA1B2_C3D4;
    st_req_in = 1'b1; st_addr_in = 32'h800; st_func3_in = 3'd2; st_data_in = w;
    io_buffer_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("sw byte%0d wr/addr/data", k), {mem_wr, mem_a, mem_dout},
          {1'b1, 32'h800 + 32'(k), w[8*k +: 8]});
    end
    @(negedge clk);
    chk("sw st_done", st_done_out, 1);
    st_req_in = 1'b0; io_buffer_full = 1'b0;
    @(negedge clk);
    run_load(1'b0, 32'h800, 3'd2, d, dc, ws, pa);
    chk("sw readback data", d, w);
    chk("sw readback cycle", dc, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
